// File: rtl/fire_control_unit_if.sv
// Signal bundle between the operator/tracking side and the fire control unit.
// master: drives commands and tracking data, observes launcher status.
// slave:  the fire control unit itself.
interface fire_control_unit_if;
  logic        arm_command;
  logic        fire_command;
  logic        reload;
  logic        target_locked;
  logic [13:0] distance_to_target;
  logic        launch_missile;
  logic        fire_rejected;
  logic [2:0]  remaining_missiles;
  logic [13:0] engaged_distance;
  logic        out_of_ammo;
  logic [2:0]  FCU_state;

  modport master (
    output arm_command, fire_command, reload, target_locked, distance_to_target,
    input  launch_missile, fire_rejected, remaining_missiles, engaged_distance,
           out_of_ammo, FCU_state
  );

  modport slave (
    input  arm_command, fire_command, reload, target_locked, distance_to_target,
    output launch_missile, fire_rejected, remaining_missiles, engaged_distance,
           out_of_ammo, FCU_state
  );
endinterface

// File: rtl/fire_control_unit.sv
// Fire control unit: releases one missile per operator fire edge when the
// target is locked and in range, then enforces pulse width, cooldown and
// magazine accounting.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | disarmed; reload refills magazine, arm moves on
// ARMED       | waiting for a fire edge; refused edges pulse fire_rejected
// FIRING      | launch_missile held high, pulse timer counting down
// COOLDOWN    | launcher settling; fire edges refused
// OUT_OF_AMMO | magazine empty; only reload leaves this state
module fire_control_unit #(
  parameter int MISSILE_COUNT     = 4,
  parameter int FIRE_PULSE_CYCLES = 5,
  parameter int COOLDOWN_CYCLES   = 20,
  parameter int MIN_RANGE         = 150,
  parameter int MAX_RANGE         = 12000
) (
  input logic                clk,
  input logic                rst,
  fire_control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ARMED       = 3'd1,
    S_FIRING      = 3'd2,
    S_COOLDOWN    = 3'd3,
    S_OUT_OF_AMMO = 3'd4
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(FIRE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [2:0]       MAG_FULL   = 3'(MISSILE_COUNT);
  localparam logic [13:0]      RANGE_LO   = 14'(MIN_RANGE);
  localparam logic [13:0]      RANGE_HI   = 14'(MAX_RANGE);

  state_e           state_q, state_d;
  logic             launch_q, launch_d;
  logic             rejected_q, rejected_d;
  logic [2:0]       remaining_q, remaining_d;
  logic [13:0]      engaged_q, engaged_d;
  logic             ooa_q, ooa_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_prev_q, fire_prev_d;

  logic fire_rise;
  logic in_range;
  logic shot_ok;

  assign fire_rise = bus.fire_command & ~fire_prev_q;
  assign in_range  = (bus.distance_to_target >= RANGE_LO) &&
                     (bus.distance_to_target <= RANGE_HI);
  assign shot_ok   = bus.target_locked & in_range;

  // Next-state and registered-output values; the timer is a down-counter
  // loaded on phase entry and compared against zero for phase end.
  always_comb begin
    state_d     = state_q;
    launch_d    = launch_q;
    rejected_d  = 1'b0;
    remaining_d = remaining_q;
    engaged_d   = engaged_q;
    cnt_d       = cnt_q;
    fire_prev_d = bus.fire_command;

    case (state_q)
      S_IDLE: begin
        if (bus.reload) begin
          remaining_d = MAG_FULL;
        end else if (bus.arm_command) begin
          state_d = (remaining_q != 3'd0) ? S_ARMED : S_OUT_OF_AMMO;
        end
      end
      S_ARMED: begin
        // Disarm wins over a coincident fire edge, silently.
        if (!bus.arm_command) begin
          state_d = S_IDLE;
        end else if (fire_rise) begin
          if (shot_ok) begin
            state_d     = S_FIRING;
            launch_d    = 1'b1;
            remaining_d = remaining_q - 3'd1;
            engaged_d   = bus.distance_to_target;
            cnt_d       = PULSE_LOAD;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      S_FIRING: begin
        if (cnt_q == '0) begin
          launch_d = 1'b0;
          state_d  = S_COOLDOWN;
          cnt_d    = COOL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (fire_rise) begin
          rejected_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if (remaining_q == 3'd0) begin
            state_d = S_OUT_OF_AMMO;
          end else if (bus.arm_command) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OUT_OF_AMMO: begin
        if (fire_rise) begin
          rejected_d = 1'b1;
        end
        if (bus.reload) begin
          remaining_d = MAG_FULL;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        launch_d = 1'b0;
      end
    endcase

    ooa_d = (state_d == S_OUT_OF_AMMO);
  end

  // State and output registers; reset drops the launch pulse immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      launch_q    <= 1'b0;
      rejected_q  <= 1'b0;
      remaining_q <= MAG_FULL;
      engaged_q   <= '0;
      ooa_q       <= 1'b0;
      cnt_q       <= '0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      rejected_q  <= rejected_d;
      remaining_q <= remaining_d;
      engaged_q   <= engaged_d;
      ooa_q       <= ooa_d;
      cnt_q       <= cnt_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  assign bus.launch_missile     = launch_q;
  assign bus.fire_rejected      = rejected_q;
  assign bus.remaining_missiles = remaining_q;
  assign bus.engaged_distance   = engaged_q;
  assign bus.out_of_ammo        = ooa_q;
  assign bus.FCU_state          = state_q;

endmodule

// File: tb/tb_fire_control_unit.sv
// Bench for fire_control_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_fire_control_unit;
  localparam int N    = 4;
  localparam int P    = 5;
  localparam int C    = 20;
  localparam int MINR = 150;
  localparam int MAXR = 12000;

  localparam int IDLE = 0, ARMED = 1, FIRING = 2, COOLDOWN = 3, OOA = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fire_control_unit_if bus();

  fire_control_unit #(
    .MISSILE_COUNT(N), .FIRE_PULSE_CYCLES(P), .COOLDOWN_CYCLES(C),
    .MIN_RANGE(MINR), .MAX_RANGE(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus elapsed cycles since the accepting edge.
  int m_state = IDLE;
  int m_rem   = N;
  int m_eng   = 0;
  int m_el    = 0;
  bit m_prev  = 0;
  bit m_rej   = 0;

  task automatic model_reset();
    m_state = IDLE; m_rem = N; m_eng = 0; m_el = 0; m_prev = 0; m_rej = 0;
  endtask

  task automatic model_step();
    bit rise;
    int d;
    rise   = bus.fire_command && !m_prev;
    m_prev = bus.fire_command;
    m_rej  = 0;
    d      = int'(bus.distance_to_target);
    case (m_state)
      IDLE: begin
        if (bus.reload) m_rem = N;
        else if (bus.arm_command) m_state = (m_rem > 0) ? ARMED : OOA;
      end
      ARMED: begin
        if (!bus.arm_command) m_state = IDLE;
        else if (rise) begin
          if (bus.target_locked && d >= MINR && d <= MAXR) begin
            m_state = FIRING; m_rem = m_rem - 1; m_eng = d; m_el = 0;
          end else m_rej = 1;
        end
      end
      FIRING: begin
        m_el++;
        if (m_el == P) m_state = COOLDOWN;
      end
      COOLDOWN: begin
        if (rise) m_rej = 1;
        m_el++;
        if (m_el == P + C) begin
          if (m_rem == 0) m_state = OOA;
          else if (bus.arm_command) m_state = ARMED;
          else m_state = IDLE;
        end
      end
      default: begin
        if (rise) m_rej = 1;
        if (bus.reload) begin m_rem = N; m_state = IDLE; end
      end
    endcase
  endtask

  // Advance the model on each edge, then compare every output just after it.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("cyc_state",  bus.FCU_state,          m_state);
    chk("cyc_launch", bus.launch_missile,     (m_state == FIRING) ? 1 : 0);
    chk("cyc_reject", bus.fire_rejected,      m_rej);
    chk("cyc_remain", bus.remaining_missiles, m_rem);
    chk("cyc_engdst", bus.engaged_distance,   m_eng);
    chk("cyc_ooa",    bus.out_of_ammo,        (m_state == OOA) ? 1 : 0);
  end

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic shot(input int d);
    @(negedge clk);
    bus.distance_to_target = 14'(d);
    bus.fire_command       = 1'b1;
    pos();
  endtask

  int rej_d[2] = '{100, 12001};
  int acc_d[2] = '{150, 12000};

  initial begin
    int launches;
    logic pl;
    bus.arm_command = 0; bus.fire_command = 0; bus.reload = 0;
    bus.target_locked = 0; bus.distance_to_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_state",  bus.FCU_state, 0);
    chk("rst_remain", bus.remaining_missiles, 4);
    chk("rst_engdst", bus.engaged_distance, 0);
    chk("rst_launch", bus.launch_missile, 0);
    chk("rst_ooa",    bus.out_of_ammo, 0);
    rst = 1;

    // Reset mid-pulse
    @(negedge clk);
    bus.arm_command = 1; bus.target_locked = 1; bus.distance_to_target = 14'd3000;
    @(negedge clk);
    bus.fire_command = 1;
    pos();
    chk("t1_launch_on", bus.launch_missile, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t1_launch_abort", bus.launch_missile, 0);
    chk("t1_state",        bus.FCU_state, 0);
    chk("t1_remain",       bus.remaining_missiles, 4);
    @(negedge clk);
    rst = 1; bus.fire_command = 0;

    // Full shot timeline
    @(negedge clk);
    bus.fire_command = 1;
    pos();
    chk("t2_launch", bus.launch_missile, 1);
    chk("t2_engdst", bus.engaged_distance, 3000);
    chk("t2_remain", bus.remaining_missiles, 3);
    chk("t2_state",  bus.FCU_state, 2);
    for (int i = 1; i < 5; i++) begin
      pos();
      chk("t2_pulse_high", bus.launch_missile, 1);
    end
    pos();
    chk("t2_pulse_end", bus.launch_missile, 0);
    chk("t2_cool_entry", bus.FCU_state, 3);
    for (int i = 0; i < 19; i++) begin
      pos();
      chk("t2_cooldown", bus.FCU_state, 3);
    end
    pos();
    chk("t2_rearmed", bus.FCU_state, 1);
    @(negedge clk);
    bus.fire_command = 0;

    // Range boundaries
    for (int i = 0; i < 2; i++) begin
      shot(rej_d[i]);
      chk("t3_reject_pulse", bus.fire_rejected, 1);
      chk("t3_reject_nolaunch", bus.launch_missile, 0);
      chk("t3_reject_remain", bus.remaining_missiles, 3);
      pos();
      chk("t3_reject_1clk", bus.fire_rejected, 0);
      @(negedge clk);
      bus.fire_command = 0;
    end
    for (int i = 0; i < 2; i++) begin
      shot(acc_d[i]);
      chk("t3_accept_launch", bus.launch_missile, 1);
      chk("t3_accept_engdst", bus.engaged_distance, acc_d[i]);
      chk("t3_accept_remain", bus.remaining_missiles, 2 - i);
      repeat (25) @(posedge clk);
      #1;
      chk("t3_accept_rearm", bus.FCU_state, 1);
      @(negedge clk);
      bus.fire_command = 0;
    end

    // Held fire command, then a rise during cooldown
    @(negedge clk); bus.arm_command = 0;
    @(negedge clk); bus.reload = 1;
    @(negedge clk); bus.reload = 0; bus.arm_command = 1;
    chk("t4_refill", bus.remaining_missiles, 4);
    @(negedge clk);
    bus.distance_to_target = 14'd3000; bus.fire_command = 1;
    launches = 0; pl = 0;
    repeat (100) begin
      pos();
      if (bus.launch_missile && !pl) launches++;
      pl = bus.launch_missile;
    end
    chk("t4_one_launch", launches, 1);
    chk("t4_remain", bus.remaining_missiles, 3);
    @(negedge clk);
    bus.fire_command = 0;
    shot(3000);
    chk("t4_second_shot", bus.launch_missile, 1);
    @(negedge clk);
    bus.fire_command = 0;
    repeat (8) @(negedge clk);
    bus.fire_command = 1;
    pos();
    chk("t4_cool_reject", bus.fire_rejected, 1);
    chk("t4_cool_state",  bus.FCU_state, 3);
    @(negedge clk);
    bus.fire_command = 0;
    repeat (30) @(negedge clk);

    // Empty the magazine
    for (int k = 0; k < 2; k++) begin
      shot(5000);
      chk("t5_launch", bus.launch_missile, 1);
      @(negedge clk);
      bus.fire_command = 0;
      repeat (26) @(negedge clk);
    end
    chk("t5_state_ooa", bus.FCU_state, 4);
    chk("t5_ooa_flag",  bus.out_of_ammo, 1);
    chk("t5_remain0",   bus.remaining_missiles, 0);
    bus.fire_command = 1;
    pos();
    chk("t5_ooa_reject", bus.fire_rejected, 1);
    @(negedge clk);
    bus.fire_command = 0; bus.reload = 1;
    pos();
    chk("t5_reload_state", bus.FCU_state, 0);
    chk("t5_reload_remain", bus.remaining_missiles, 4);
    chk("t5_reload_ooa", bus.out_of_ammo, 0);
    @(negedge clk);
    bus.reload = 0;

    // Disarm coincident with fire edge
    repeat (2) @(negedge clk);
    chk("t6_armed", bus.FCU_state, 1);
    bus.arm_command = 0; bus.fire_command = 1;
    pos();
    chk("t6_state",  bus.FCU_state, 0);
    chk("t6_launch", bus.launch_missile, 0);
    chk("t6_reject", bus.fire_rejected, 0);
    @(negedge clk);
    bus.fire_command = 0;

    // Randomized traffic
    repeat (4000) begin
      @(negedge clk);
      if (!rst) rst = 1;
      else if ($urandom_range(0, 499) == 0) rst = 0;
      bus.arm_command   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus.fire_command = ~bus.fire_command;
      bus.reload        = ($urandom_range(0, 19) == 0);
      bus.target_locked = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 8))
        0: bus.distance_to_target = 14'd100;
        1: bus.distance_to_target = 14'd149;
        2: bus.distance_to_target = 14'd150;
        3: bus.distance_to_target = 14'd151;
        4: bus.distance_to_target = 14'd3000;
        5: bus.distance_to_target = 14'd11999;
        6: bus.distance_to_target = 14'd12000;
        7: bus.distance_to_target = 14'd12001;
        default: bus.distance_to_target = 14'($urandom_range(0, 16383));
      endcase
    end
    @(negedge clk);
    rst = 1;
    pos();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
